alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream feeder for the 8-bit combinational ALU (ports opa/opb/mux/result).
//  Buffers operand/opcode commands in a small FIFO, drives the ALU from registers,
//  captures the ALU result and returns it on a valid/ready output channel.
//  Decouples the ALU from bursty producers and stalling consumers.
// PARAMETERS
//  W      8  operand/result width; must match the ALU width
//  OPW    4  opcode width (ALU mux select)
//  DEPTH  4  command FIFO entries; power of two, >=2
// PORTS
//  clk         in   1                   single clock, rising edge
//  rst_n       in   1                   async active-low reset
//  in_valid    in   1                   command present
//  in_ready    out  1                   FIFO can accept (= !full)
//  in_opa      in   W                   operand A
//  in_opb      in   W                   operand B
//  in_op       in   OPW                 opcode 0x0..0xB (ALU encoding)
//  alu_opa     out  W                   registered operand A to ALU
//  alu_opb     out  W                   registered operand B to ALU
//  alu_mux     out  OPW                 registered opcode to ALU
//  alu_result  in   W                   combinational ALU result
//  out_valid   out  1                   result available
//  out_ready   in   1                   consumer accepts result
//  out_result  out  W                   captured result
//  out_op      out  OPW                 opcode that produced out_result
//  count       out  $clog2(DEPTH+1)     FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, count=0, FSM=IDLE, alu_opa/opb/mux=0,
//   out_valid=0, out_result=0, out_op=0, in_ready=1 once released. In-flight
//   commands discarded; no partial result emitted after reset.
//  Input: push on clk edge when in_valid&&in_ready. in_ready=0 when count==DEPTH.
//   No bypass: a push while full is not taken, even if a pop occurs that cycle.
//   Push and pop in the same cycle: count unchanged.
//  FSM:
//   IDLE: if count>0, pop head into alu_* regs -> EXEC; else stay.
//   EXEC: ALU inputs stable for one full cycle; at edge, out_result<=alu_result,
//    out_op<=alu_mux, out_valid<=1 -> HOLD.
//   HOLD: out_valid/out_result/out_op held stable until out_valid&&out_ready.
//    On handshake: if count>0, pop next into alu_* -> EXEC (out_valid<=0 same edge);
//    else -> IDLE, out_valid<=0.
//  alu_* regs change only on pop; they hold the last command in IDLE/HOLD.
//  Latency: command pushed at edge k into idle empty block -> popped at k+1,
//   out_valid high after edge k+2. Throughput: 1 result per 2 cycles with
//   out_ready held at 1.
//  Capacity with out_ready=0: 1 command in HOLD + DEPTH in FIFO.
//  Width: results are W bits, truncated exactly as the ALU produces (mul low W
//   bits, div integer quotient); sequencer does not re-evaluate them.
//  FIFO pointers wrap modulo DEPTH; count distinguishes full from empty.
// CONFIGURATION
//  ALU_SEQ_ERR_EN defined: extra port out_err (out, 1), captured with out_result.
//   out_err=1 and out_result forced to 0 when opcode >0xB or (op==0x3 && opb==0).
//   Reset value 0. Command is still consumed and handshaken normally.
//  Undefined: no out_err port; out_result is whatever alu_result presents
//   for every opcode, no checking.
// TESTING (opa=0x6A, opb=0x3B unless stated)
//  Reset, push op 0x0 with out_ready=1 -> out_valid 2 cycles after push,
//   out_result=0xA5, out_op=0x0; then out_valid=0.
//  Push ops 0x1,0x2,0x3,0x5,0x9,0xA,0xB back-to-back -> results in order
//   0x2F,0x6E,0x01,0x2A,0x51,0xD4,0x35; one result every 2 cycles.
//  out_ready=0, push continuously -> 5 accepted, then in_ready=0, count=4;
//   out_result stable at first result; release out_ready -> all 5 drain in order.
//  Push and pop in the same cycle at count=2 -> count stays 2; push at
//   count=4 with in_valid=1 -> not accepted, no data lost or duplicated.
//  Assert rst_n=0 in EXEC with 3 queued -> immediately out_valid=0, count=0,
//   alu_*=0; after release no stale result appears.
//  ALU_SEQ_ERR_EN: op 0x3 with opb=0x00 -> out_err=1, out_result=0x00;
//   op 0xC -> out_err=1; op 0x0 -> out_err=0, out_result=0xA5.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus IDLE/EXEC/HOLD sequencer that drives a combinational ALU and returns its results.
// Defining ALU_SEQ_ERR_EN adds out_err, which flags invalid opcodes and divide-by-zero and zeroes the result.
module alu_cmd_sequencer #(
    parameter int W     = 8,
    parameter int OPW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_opa,
    input  logic [W-1:0]                 in_opb,
    input  logic [OPW-1:0]               in_op,
    output logic [W-1:0]                 alu_opa,
    output logic [W-1:0]                 alu_opb,
    output logic [OPW-1:0]               alu_mux,
    input  logic [W-1:0]                 alu_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_result,
    output logic [OPW-1:0]               out_op,
`ifdef ALU_SEQ_ERR_EN
    output logic                         out_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * W + OPW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic [W-1:0]    r_aluOpa;
    logic [W-1:0]    r_aluOpb;
    logic [OPW-1:0]  r_aluMux;
    logic            r_outValid;
    logic [W-1:0]    r_outResult;
    logic [OPW-1:0]  r_outOp;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            w_release;
    logic [W-1:0]    w_headOpa;
    logic [W-1:0]    w_headOpb;
    logic [OPW-1:0]  w_headOp;
    logic [W-1:0]    w_result;

    // No bypass: a full FIFO refuses a push even when a pop happens on the same edge.
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;

    assign {w_headOpa, w_headOpb, w_headOp} = r_mem[r_rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (!w_empty) w_nextState = S_EXEC;
            S_EXEC: w_nextState = S_HOLD;
            S_HOLD: if (out_ready) w_nextState = w_empty ? S_IDLE : S_EXEC;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty;
            S_EXEC: w_capture = 1'b1;
            S_HOLD: begin
                w_release = out_ready;
                w_pop     = out_ready && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {in_opa, in_opb, in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_SEQ_ERR_EN
    logic w_err;
    logic r_outErr;

    assign w_err    = (r_aluMux > OPW'(11)) || ((r_aluMux == OPW'(3)) && (r_aluOpb == '0));
    assign w_result = w_err ? '0 : alu_result;
    assign out_err  = r_outErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outErr <= 1'b0;
        end else if (w_capture) begin
            r_outErr <= w_err;
        end
    end
`else
    assign w_result = alu_result;
`endif

    // ALU operands only move on a pop so the ALU sees them stable through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aluOpa    <= '0;
            r_aluOpb    <= '0;
            r_aluMux    <= '0;
            r_outValid  <= 1'b0;
            r_outResult <= '0;
            r_outOp     <= '0;
        end else begin
            if (w_pop) begin
                r_aluOpa <= w_headOpa;
                r_aluOpb <= w_headOpb;
                r_aluMux <= w_headOp;
            end
            if (w_capture) begin
                r_outResult <= w_result;
                r_outOp     <= r_aluMux;
                r_outValid  <= 1'b1;
            end else if (w_release) begin
                r_outValid  <= 1'b0;
            end
        end
    end

    assign alu_opa    = r_aluOpa;
    assign alu_opb    = r_aluOpb;
    assign alu_mux    = r_aluMux;
    assign out_valid  = r_outValid;
    assign out_result = r_outResult;
    assign out_op     = r_outOp;
    assign count      = r_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU stub on the alu_* ports.
// Also covers out_err when built with ALU_SEQ_ERR_EN.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rstN;
    logic       inValid;
    logic       inReady;
    logic [7:0] inOpa;
    logic [7:0] inOpb;
    logic [3:0] inOp;
    logic [7:0] aluOpa;
    logic [7:0] aluOpb;
    logic [3:0] aluMux;
    logic [7:0] aluResult;
    logic       outValid;
    logic       outReady;
    logic [7:0] outResult;
    logic [3:0] outOp;
    logic [2:0] count;
`ifdef ALU_SEQ_ERR_EN
    logic       outErr;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] pOpa [8];
    logic [7:0] pOpb [8];
    logic [3:0] pOp  [8];
    logic [7:0] expRes [8];
    logic [3:0] expOp  [8];
    logic       expErr [8];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.W(8), .OPW(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_opa     (inOpa),
        .in_opb     (inOpb),
        .in_op      (inOp),
        .alu_opa    (aluOpa),
        .alu_opb    (aluOpb),
        .alu_mux    (aluMux),
        .alu_result (aluResult),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_op     (outOp),
`ifdef ALU_SEQ_ERR_EN
        .out_err    (outErr),
`endif
        .count      (count)
    );

    // Behavioural stand-in for the combinational ALU.
    always_comb begin
        case (aluMux)
            4'h0: aluResult = aluOpa + aluOpb;
            4'h1: aluResult = aluOpa - aluOpb;
            4'h2: aluResult = aluOpa * aluOpb;
            4'h3: aluResult = (aluOpb == 8'h00) ? 8'hFF : aluOpa / aluOpb;
            4'h4: aluResult = (aluOpb == 8'h00) ? 8'hFF : aluOpa % aluOpb;
            4'h5: aluResult = aluOpa & aluOpb;
            4'h6: aluResult = aluOpa | aluOpb;
            4'h7: aluResult = ~(aluOpa & aluOpb);
            4'h8: aluResult = ~aluOpa;
            4'h9: aluResult = aluOpa ^ aluOpb;
            4'hA: aluResult = aluOpa << 1;
            4'hB: aluResult = aluOpa >> 1;
            default: aluResult = 8'hEE;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op, input logic rdy);
        inValid  = v;
        inOpa    = a;
        inOpb    = b;
        inOp     = op;
        outReady = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic pushSeq(input int n);
        for (int i = 0; i < n; i++) begin
            int waitCyc = 0;
            applyStimulus(1'b1, pOpa[i], pOpb[i], pOp[i], outReady);
            while (!inReady && waitCyc < 20) begin
                tick();
                waitCyc++;
            end
            checkOutput($sformatf("push_ready_%0d", i), 32'(inReady), 32'd1);
            tick();
        end
        inValid = 1'b0;
    endtask

    task automatic collect(input int n, input int maxCyc, input bit checkGap);
        int got = 0;
        int lastCyc = 0;
        for (int cyc = 0; cyc < maxCyc && got < n; cyc++) begin
            if (outValid && outReady) begin
                checkOutput($sformatf("res_%0d", got), 32'(outResult), 32'(expRes[got]));
                checkOutput($sformatf("op_%0d", got), 32'(outOp), 32'(expOp[got]));
`ifdef ALU_SEQ_ERR_EN
                checkOutput($sformatf("err_%0d", got), 32'(outErr), 32'(expErr[got]));
`endif
                if (checkGap && got > 0) begin
                    checkOutput($sformatf("gap_%0d", got), 32'(cyc - lastCyc), 32'd2);
                end
                lastCyc = cyc;
                got++;
            end
            tick();
        end
        checkOutput("collect_count", 32'(got), 32'(n));
    endtask

    initial begin
        int accepted;
        int staleSeen;
        logic [3:0] fillOp [6];
        logic [3:0] streamOp [7];
        logic [7:0] streamRes [7];

        applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b0);
        rstN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pOpa[i] = 8'h6A;
            pOpb[i] = 8'h3B;
            pOp[i] = 4'h0;
            expErr[i] = 1'b0;
        end

        // Reset state.
        #2;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_alu_opa", 32'(aluOpa), 32'd0);
        checkOutput("rst_alu_mux", 32'(aluMux), 32'd0);
        checkOutput("rst_result", 32'(outResult), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        @(negedge clk);

        // Single command latency.
        $display("[TB] single op 0x0");
        applyStimulus(1'b1, 8'h6A, 8'h3B, 4'h0, 1'b1);
        tick();
        inValid = 1'b0;
        checkOutput("lat_count1", 32'(count), 32'd1);
        checkOutput("lat_valid1", 32'(outValid), 32'd0);
        tick();
        checkOutput("lat_alu_opa", 32'(aluOpa), 32'h6A);
        checkOutput("lat_alu_opb", 32'(aluOpb), 32'h3B);
        checkOutput("lat_alu_mux", 32'(aluMux), 32'h0);
        checkOutput("lat_valid2", 32'(outValid), 32'd0);
        checkOutput("lat_count2", 32'(count), 32'd0);
        tick();
        checkOutput("lat_valid3", 32'(outValid), 32'd1);
        checkOutput("lat_result", 32'(outResult), 32'hA5);
        checkOutput("lat_op", 32'(outOp), 32'h0);
        tick();
        checkOutput("lat_valid4", 32'(outValid), 32'd0);
        checkOutput("lat_alu_hold", 32'(aluOpa), 32'h6A);

        // Back-to-back stream at full throughput.
        $display("[TB] stream of seven ops");
        streamOp  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hA, 4'hB};
        streamRes = '{8'h2F, 8'h6E, 8'h01, 8'h2A, 8'h51, 8'hD4, 8'h35};
        for (int i = 0; i < 7; i++) begin
            pOp[i] = streamOp[i];
            expOp[i] = streamOp[i];
            expRes[i] = streamRes[i];
        end
        outReady = 1'b1;
        fork
            pushSeq(7);
            collect(7, 60, 1'b1);
        join

        // Backpressure fill, then release with a refused push on the same edge.
        $display("[TB] backpressure");
        doReset();
        fillOp = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9};
        accepted = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            logic took;
            applyStimulus(1'b1, 8'h6A, 8'h3B, fillOp[(accepted < 5) ? accepted : 5], 1'b0);
            took = inReady;
            tick();
            if (took) accepted++;
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd5);
        checkOutput("bp_in_ready", 32'(inReady), 32'd0);
        checkOutput("bp_count", 32'(count), 32'd4);
        checkOutput("bp_valid", 32'(outValid), 32'd1);
        checkOutput("bp_result", 32'(outResult), 32'hA5);
        checkOutput("bp_op", 32'(outOp), 32'h0);
        applyStimulus(1'b1, 8'h6A, 8'h3B, 4'h9, 1'b1);
        tick();
        inValid = 1'b0;
        checkOutput("nobypass_count", 32'(count), 32'd3);
        expOp[0] = 4'h1; expRes[0] = 8'h2F;
        expOp[1] = 4'h2; expRes[1] = 8'h6E;
        expOp[2] = 4'h3; expRes[2] = 8'h01;
        expOp[3] = 4'h5; expRes[3] = 8'h2A;
        collect(4, 30, 1'b1);
        tick();
        tick();
        checkOutput("bp_no_extra", 32'(outValid), 32'd0);
        checkOutput("bp_empty", 32'(count), 32'd0);

        // Simultaneous push and pop at count 2.
        $display("[TB] push and pop at count 2");
        doReset();
        pOp[0] = 4'h0; pOp[1] = 4'h1; pOp[2] = 4'h2;
        pushSeq(3);
        checkOutput("pp_count_before", 32'(count), 32'd2);
        checkOutput("pp_valid_before", 32'(outValid), 32'd1);
        applyStimulus(1'b1, 8'h6A, 8'h3B, 4'h5, 1'b1);
        tick();
        inValid = 1'b0;
        checkOutput("pp_count_after", 32'(count), 32'd2);
        expOp[0] = 4'h1; expRes[0] = 8'h2F;
        expOp[1] = 4'h2; expRes[1] = 8'h6E;
        expOp[2] = 4'h5; expRes[2] = 8'h2A;
        collect(3, 30, 1'b1);

        // Asynchronous reset while in EXEC with three queued.
        $display("[TB] reset during EXEC");
        doReset();
        pOp[0] = 4'h0; pOp[1] = 4'h1; pOp[2] = 4'h2; pOp[3] = 4'h3;
        pushSeq(4);
        applyStimulus(1'b1, 8'h6A, 8'h3B, 4'h5, 1'b1);
        tick();
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        checkOutput("pre_rst_valid", 32'(outValid), 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_alu_opa", 32'(aluOpa), 32'd0);
        checkOutput("mid_rst_alu_opb", 32'(aluOpb), 32'd0);
        checkOutput("mid_rst_alu_mux", 32'(aluMux), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        staleSeen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (outValid) staleSeen++;
        end
        checkOutput("no_stale", 32'(staleSeen), 32'd0);

`ifdef ALU_SEQ_ERR_EN
        $display("[TB] error flag");
        doReset();
        outReady = 1'b1;
        pOpa[0] = 8'h6A; pOpb[0] = 8'h00; pOp[0] = 4'h3;
        pOpa[1] = 8'h6A; pOpb[1] = 8'h3B; pOp[1] = 4'hC;
        pOpa[2] = 8'h6A; pOpb[2] = 8'h3B; pOp[2] = 4'h0;
        expRes[0] = 8'h00; expOp[0] = 4'h3; expErr[0] = 1'b1;
        expRes[1] = 8'h00; expOp[1] = 4'hC; expErr[1] = 1'b1;
        expRes[2] = 8'hA5; expOp[2] = 4'h0; expErr[2] = 1'b0;
        fork
            pushSeq(3);
            collect(3, 40, 1'b1);
        join
`else
        $display("[TB] unchecked opcode passes through");
        doReset();
        outReady = 1'b1;
        pOpa[0] = 8'h6A; pOpb[0] = 8'h3B; pOp[0] = 4'hC;
        expRes[0] = 8'hEE; expOp[0] = 4'hC;
        fork
            pushSeq(1);
            collect(1, 20, 1'b0);
        join
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
